// File: rtl/pdp11_mem_arbiter_pkg.sv
// Shared types and defaults for the PDP-11 flash port arbiter.
package pdp11_mem_arbiter_pkg;

    // Data grants a waiting fetch tolerates before it is forced through.
    localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

    typedef enum logic [2:0] {
        IDLE,
        BYTE0,
        BYTE1,
        WAIT,
        ACK
    } arb_state_t;

    typedef enum logic {
        OWNER_FETCH,
        OWNER_DATA
    } arb_owner_t;

endpackage

// File: rtl/pdp11_mem_arbiter.sv
// Byte-wide flash port arbiter: instruction fetch vs. data access.
// Words are split into two big-endian byte cycles (addr, addr+1 mod 2^ADDR_WIDTH).
module pdp11_mem_arbiter
    import pdp11_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ack,
    output logic [15:0]           fetch_rdata,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic                  data_byte,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [15:0]           data_wdata,
    output logic                  data_ack,
    output logic [15:0]           data_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    output logic                  busy
);

    localparam int unsigned StarveW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

    arb_state_t            state_q;
    arb_owner_t            owner_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic                  byte_q;
    logic [7:0]            wdata_lo_q;
    logic [7:0]            hi_q;
    logic [StarveW-1:0]    starve_q, starve_d;
    logic                  fetch_ack_q, data_ack_q;
    logic [15:0]           fetch_rdata_q, data_rdata_q;
    logic                  mem_en_q, mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [7:0]            mem_wdata_q;
    logic                  busy_q;

    logic                  grant_fetch, grant_data;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic                  grant_we, grant_byte;
    logic [15:0]           grant_wdata;

    // Arbitration: data wins unless fetch has waited out the starvation limit.
    always_comb begin
        grant_fetch = fetch_req && (!data_req || (starve_q == StarveMax));
        grant_data  = data_req && !grant_fetch;
        starve_d    = starve_q;
        if (!fetch_req || grant_fetch) begin
            starve_d = '0;
        end else if (grant_data && (starve_q != StarveMax)) begin
            starve_d = starve_q + StarveW'(1);
        end
        grant_addr  = grant_fetch ? fetch_addr : data_addr;
        grant_we    = grant_data && data_we;
        grant_byte  = grant_data && data_byte;
        grant_wdata = grant_data ? data_wdata : 16'h0000;
    end

    // Transaction FSM; every output is a register set on entry to the state using it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            owner_q       <= OWNER_FETCH;
            addr_q        <= '0;
            we_q          <= 1'b0;
            byte_q        <= 1'b0;
            wdata_lo_q    <= '0;
            hi_q          <= '0;
            starve_q      <= '0;
            fetch_ack_q   <= 1'b0;
            data_ack_q    <= 1'b0;
            fetch_rdata_q <= '0;
            data_rdata_q  <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            fetch_ack_q <= 1'b0;
            data_ack_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    starve_q <= starve_d;
                    if (grant_fetch || grant_data) begin
                        state_q     <= BYTE0;
                        owner_q     <= grant_fetch ? OWNER_FETCH : OWNER_DATA;
                        addr_q      <= grant_addr;
                        we_q        <= grant_we;
                        byte_q      <= grant_byte;
                        wdata_lo_q  <= grant_wdata[7:0];
                        busy_q      <= 1'b1;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= grant_we;
                        mem_addr_q  <= grant_addr;
                        mem_wdata_q <= grant_byte ? grant_wdata[7:0] : grant_wdata[15:8];
                    end
                end
                BYTE0: begin
                    if (!byte_q) begin
                        state_q     <= BYTE1;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= we_q;
                        mem_addr_q  <= addr_q + ADDR_WIDTH'(1);
                        mem_wdata_q <= wdata_lo_q;
                    end else if (we_q) begin
                        state_q     <= ACK;
                        fetch_ack_q <= (owner_q == OWNER_FETCH);
                        data_ack_q  <= (owner_q == OWNER_DATA);
                    end else begin
                        state_q <= WAIT;
                    end
                end
                BYTE1: begin
                    // High byte from the BYTE0 read lands this cycle.
                    if (we_q) begin
                        state_q     <= ACK;
                        fetch_ack_q <= (owner_q == OWNER_FETCH);
                        data_ack_q  <= (owner_q == OWNER_DATA);
                    end else begin
                        hi_q    <= mem_rdata;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    state_q <= ACK;
                    if (owner_q == OWNER_FETCH) begin
                        fetch_rdata_q <= byte_q ? {8'h00, mem_rdata} : {hi_q, mem_rdata};
                        fetch_ack_q   <= 1'b1;
                    end else begin
                        data_rdata_q <= byte_q ? {8'h00, mem_rdata} : {hi_q, mem_rdata};
                        data_ack_q   <= 1'b1;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_ack   = fetch_ack_q;
    assign fetch_rdata = fetch_rdata_q;
    assign data_ack    = data_ack_q;
    assign data_rdata  = data_rdata_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pdp11_mem_arbiter.sv
// Scoreboard bench for pdp11_mem_arbiter with a behavioural 64 KiB flash model.
module tb_pdp11_mem_arbiter;

    logic        clock;
    logic        reset_n;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ack;
    logic [15:0] fetch_rdata;
    logic        data_req, data_we, data_byte;
    logic [15:0] data_addr, data_wdata;
    logic        data_ack;
    logic [15:0] data_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;

    logic [7:0]  mem [0:65535];

    typedef struct {
        bit          is_fetch;
        logic [15:0] rdata;
        bit          chk_rdata;
        int          ack_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int en_cnt = 0;
    int f_cnt = 0;
    int d_cnt = 0;
    int base_a, base_b;

    pdp11_mem_arbiter #(
        .ADDR_WIDTH   (16),
        .STARVE_LIMIT (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ack   (fetch_ack),
        .fetch_rdata (fetch_rdata),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_byte   (data_byte),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_ack    (data_ack),
        .data_rdata  (data_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Flash model: synchronous write, read data valid the cycle after the strobe.
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: every ack pops the scoreboard and is checked for owner, data and cycle.
    always @(negedge clock) begin
        if (mem_en) en_cnt++;
        if (fetch_ack) f_cnt++;
        if (data_ack) d_cnt++;
        if (fetch_ack) check_val("ack_exclusive", data_ack, 0);
        if (fetch_ack || data_ack) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_ack", {fetch_ack, data_ack}, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("ack_owner", fetch_ack, mon_e.is_fetch);
                if (mon_e.chk_rdata) begin
                    if (mon_e.is_fetch) check_val("fetch_rdata", fetch_rdata, mon_e.rdata);
                    else                check_val("data_rdata", data_rdata, mon_e.rdata);
                end
                if (mon_e.ack_cyc >= 0) check_val("ack_cycle", cyc, mon_e.ack_cyc);
            end
        end
    end

    task automatic issue_fetch(input logic [15:0] addr, input logic [15:0] exp);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        sb_q.push_back('{is_fetch: 1'b1, rdata: exp, chk_rdata: 1'b1, ack_cyc: cyc + 4});
    endtask

    task automatic issue_data(input logic we, input logic byt, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [15:0] exp, input int lat);
        data_req   = 1'b1;
        data_we    = we;
        data_byte  = byt;
        data_addr  = addr;
        data_wdata = wdata;
        sb_q.push_back('{is_fetch: 1'b0, rdata: exp, chk_rdata: !we, ack_cyc: cyc + lat});
    endtask

    // Wait for all expected acks, release requests, then step into the next IDLE cycle.
    task automatic drain(input int budget);
        int k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(negedge clock);
            #1;
            k++;
        end
        if (sb_q.size() != 0) begin
            check_val("ack_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        @(negedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        fetch_req = 1'b0; fetch_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_byte = 1'b0; data_addr = '0; data_wdata = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0100] = 8'h15; mem[16'h0101] = 8'hC0;
        mem[16'h0201] = 8'hAB; mem[16'h0202] = 8'h5A; mem[16'h0203] = 8'h66;
        mem[16'h0301] = 8'h77;

        repeat (3) @(negedge clock);
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_mem_en", mem_en, 0);
        check_val("rst_mem_we", mem_we, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_mem_wdata", mem_wdata, 0);
        check_val("rst_fetch_ack", fetch_ack, 0);
        check_val("rst_data_ack", data_ack, 0);
        check_val("rst_fetch_rdata", fetch_rdata, 0);
        check_val("rst_data_rdata", data_rdata, 0);
        reset_n = 1'b1;
        @(negedge clock);
        #1;

        // Word fetch: two strobes, ack at n+4
        base_a = en_cnt;
        issue_fetch(16'h0100, 16'h15C0);
        drain(20);
        check_val("fetch_mem_en_cycles", en_cnt - base_a, 2);

        // Byte read, then byte write touching only its own byte
        issue_data(1'b0, 1'b1, 16'h0201, 16'h0000, 16'h00AB, 3);
        drain(20);
        issue_data(1'b1, 1'b1, 16'h0202, 16'h0034, 16'h0000, 2);
        drain(20);
        check_val("bw_mem_0201", mem[16'h0201], 8'hAB);
        check_val("bw_mem_0202", mem[16'h0202], 8'h34);
        check_val("bw_mem_0203", mem[16'h0203], 8'h66);

        // Word write/read across the top of the address space
        issue_data(1'b1, 1'b0, 16'hFFFF, 16'h1234, 16'h0000, 3);
        drain(20);
        check_val("ww_mem_ffff", mem[16'hFFFF], 8'h12);
        check_val("ww_mem_0000", mem[16'h0000], 8'h34);
        issue_data(1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h1234, 4);
        drain(20);

        // Owner drops data_req during BYTE1: transaction still completes
        base_a = f_cnt;
        base_b = d_cnt;
        issue_data(1'b0, 1'b0, 16'h0201, 16'h0000, {mem[16'h0201], mem[16'h0202]}, 4);
        @(negedge clock); #1;
        @(negedge clock); #1;
        data_req = 1'b0;
        drain(20);
        check_val("drop_data_acks", d_cnt - base_b, 1);
        check_val("drop_fetch_acks", f_cnt - base_a, 0);

        // Reset during BYTE1 of a word write
        data_req = 1'b1; data_we = 1'b1; data_byte = 1'b0;
        data_addr = 16'h0300; data_wdata = 16'hBEEF;
        @(negedge clock); #1;
        @(negedge clock); #1;
        check_val("pre_rst_mem_addr", mem_addr, 16'h0301);
        check_val("pre_rst_mem_en", mem_en, 1);
        reset_n = 1'b0;
        data_req = 1'b0;
        #1;
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_mem_en", mem_en, 0);
        check_val("mid_rst_mem_we", mem_we, 0);
        check_val("mid_rst_mem_addr", mem_addr, 0);
        check_val("mid_rst_data_ack", data_ack, 0);
        check_val("mid_rst_data_rdata", data_rdata, 0);
        @(negedge clock); #1;
        check_val("rst_part_mem_0300", mem[16'h0300], 8'hBE);
        check_val("rst_part_mem_0301", mem[16'h0301], 8'h77);
        reset_n = 1'b1;
        @(negedge clock); #1;
        issue_data(1'b0, 1'b0, 16'h0300, 16'h0000, 16'hBE77, 4);
        drain(20);

        // Contention: both held, expect D,D,D,D,F repeating, one word per 5 cycles
        base_a = cyc;
        fetch_req = 1'b1; fetch_addr = 16'h0100;
        data_req = 1'b1; data_we = 1'b0; data_byte = 1'b0; data_addr = 16'h0201;
        for (int i = 0; i < 10; i++) begin
            if ((i % 5) == 4)
                sb_q.push_back('{is_fetch: 1'b1, rdata: 16'h15C0, chk_rdata: 1'b1,
                                 ack_cyc: base_a + 4 + 5 * i});
            else
                sb_q.push_back('{is_fetch: 1'b0, rdata: {mem[16'h0201], mem[16'h0202]},
                                 chk_rdata: 1'b1, ack_cyc: base_a + 4 + 5 * i});
        end
        drain(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
